// File: rtl/line_ring_controller.sv
// Ring of NUM_LINES line slots between a sampled video input and an HDMI output.
// Define LINE_RING_STATS_EN to build the overflow/underflow statistics counters.
module line_ring_controller #(
    parameter int DATA_W    = 24,
    parameter int LINE_W    = 11,
    parameter int NUM_LINES = 4,
    localparam int LB       = $clog2(NUM_LINES),
    localparam int ADDR_W   = LB + LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_enable,
    input  logic              h_sync_in,
    input  logic              v_sync_in,
    input  logic              active_video_in,
    input  logic [DATA_W-1:0] pixel_data_in,
    input  logic              line_reset,
    input  logic              hdmi_request,
    output logic [DATA_W-1:0] pixel_data_out,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [LB-1:0]     fill_level,
    output logic              overflow,
    output logic              underflow,
    output logic [15:0]       overflow_count,
    output logic [15:0]       underflow_count
);

    localparam logic [LINE_W-1:0] COL_MAX  = '1;
    localparam logic [LB-1:0]     FILL_MAX = LB'(NUM_LINES - 2);

    logic [LB-1:0]     wr_slot_q, wr_slot_d, rd_slot_q, rd_slot_d, fill_q, fill_d;
    logic [LINE_W-1:0] wr_col_q, wr_col_d, rd_col_q, rd_col_d;
    logic              wr_done_q, wr_done_d;
    logic              lr_prev_q, req_d1_q, ovf_q, unf_q;
    logic [DATA_W-1:0] pixel_q;

    logic wr_fire, line_end, commit, drop, lr_edge, consume, repeat_line;

    // wr_done marks that column COL_MAX has been written, so later samples are dropped.
    assign wr_fire     = sample_enable & active_video_in & ~wr_done_q & ~rst;
    assign line_end    = h_sync_in & ~v_sync_in & (wr_col_q != '0);
    assign commit      = line_end & (fill_q < FILL_MAX);
    assign drop        = line_end & ~commit;
    assign lr_edge     = line_reset & ~lr_prev_q;
    assign consume     = lr_edge & (fill_q != '0);
    assign repeat_line = lr_edge & (fill_q == '0);

    always_comb begin
        wr_col_d  = wr_col_q;
        wr_done_d = wr_done_q;
        wr_slot_d = wr_slot_q;
        rd_col_d  = rd_col_q;
        rd_slot_d = rd_slot_q;
        fill_d    = fill_q;

        if (wr_fire) begin
            if (wr_col_q == COL_MAX) wr_done_d = 1'b1;
            else                     wr_col_d  = wr_col_q + 1'b1;
        end
        if (v_sync_in || line_end) begin
            wr_col_d  = '0;
            wr_done_d = 1'b0;
        end
        if (commit) wr_slot_d = wr_slot_q + 1'b1;

        if (lr_edge) begin
            rd_col_d = '0;
            if (consume) rd_slot_d = rd_slot_q + 1'b1;
        end else if (hdmi_request && rd_col_q != COL_MAX) begin
            rd_col_d = rd_col_q + 1'b1;
        end

        // Consume sees the pre-commit level; both together cancel out.
        fill_d = fill_q + LB'(commit) - LB'(consume);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_slot_q <= LB'(1);
            rd_slot_q <= '0;
            fill_q    <= '0;
            wr_col_q  <= '0;
            rd_col_q  <= '0;
            wr_done_q <= 1'b0;
            lr_prev_q <= 1'b1;
            req_d1_q  <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            pixel_q   <= '0;
        end else begin
            wr_slot_q <= wr_slot_d;
            rd_slot_q <= rd_slot_d;
            fill_q    <= fill_d;
            wr_col_q  <= wr_col_d;
            rd_col_q  <= rd_col_d;
            wr_done_q <= wr_done_d;
            lr_prev_q <= line_reset;
            req_d1_q  <= hdmi_request;
            ovf_q     <= drop;
            unf_q     <= repeat_line;
            pixel_q   <= req_d1_q ? ram_rd_data : '0;
        end
    end

`ifdef LINE_RING_STATS_EN
    logic [15:0] ovf_cnt_q, unf_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt_q <= '0;
            unf_cnt_q <= '0;
        end else begin
            if (drop && ovf_cnt_q != 16'hFFFF)        ovf_cnt_q <= ovf_cnt_q + 16'd1;
            if (repeat_line && unf_cnt_q != 16'hFFFF) unf_cnt_q <= unf_cnt_q + 16'd1;
        end
    end

    assign overflow_count  = ovf_cnt_q;
    assign underflow_count = unf_cnt_q;
`else
    assign overflow_count  = 16'd0;
    assign underflow_count = 16'd0;
`endif

    assign ram_wr_en      = wr_fire;
    assign ram_wr_addr    = wr_fire ? {wr_slot_q, wr_col_q} : '0;
    assign ram_wr_data    = wr_fire ? pixel_data_in : '0;
    assign ram_rd_addr    = {rd_slot_q, rd_col_q};
    assign pixel_data_out = pixel_q;
    assign fill_level     = fill_q;
    assign overflow       = ovf_q;
    assign underflow      = unf_q;

endmodule

// File: doc/line_ring_controller.md
LINE_RING_CONTROLLER -- requirements
Module: line_ring_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 24, pixel width.
REQ-002 SHALL have parameter LINE_W, default 11, column address bits per line.
REQ-003 SHALL have parameter NUM_LINES, default 4, ring slots; power of two, >=4; LB = log2(NUM_LINES); ADDR_W = LB+LINE_W.
REQ-004 SHALL have ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous active-high reset.
- sample_enable  in  1  ADC sample strobe.
- h_sync_in  in  1  end-of-line pulse.
- v_sync_in  in  1  end-of-frame pulse.
- active_video_in  in  1  capture window.
- pixel_data_in  in  DATA_W  pixel to store.
- line_reset  in  1  level; rising edge = output line start.
- hdmi_request  in  1  output pixel demand.
- pixel_data_out  out  DATA_W  output pixel.
- ram_wr_en  out  1  RAM write enable.
- ram_wr_addr  out  ADDR_W  {slot,column}.
- ram_wr_data  out  DATA_W  RAM write data.
- ram_rd_addr  out  ADDR_W  {slot,column}.
- ram_rd_data  in  DATA_W  RAM data, valid 1 cycle after ram_rd_addr.
- fill_level  out  LB  committed unread lines.
- overflow  out  1  one-cycle line-drop pulse.
- underflow  out  1  one-cycle line-repeat pulse.
- overflow_count, underflow_count  out  16 each  statistics.

Function
REQ-005 Write: when sample_enable && active_video_in, SHALL assert ram_wr_en same cycle with ram_wr_addr={wr_slot,wr_col}, ram_wr_data=pixel_data_in, then increment wr_col.
REQ-006 wr_col SHALL saturate at 2^LINE_W-1; writes past it SHALL be suppressed (ram_wr_en low).
REQ-007 Commit: on h_sync_in with wr_col!=0 and fill_level<NUM_LINES-2, SHALL advance wr_slot (mod NUM_LINES), increment fill_level, clear wr_col.
REQ-008 On h_sync_in with wr_col!=0 and fill_level==NUM_LINES-2, SHALL discard the line (wr_slot unchanged), clear wr_col, pulse overflow next cycle.
REQ-009 h_sync_in with wr_col==0 SHALL have no effect.
REQ-010 v_sync_in SHALL clear wr_col without commit; simultaneous h_sync_in is ignored.
REQ-011 Consume: on line_reset rising edge (registered prior value), SHALL clear rd_col; if fill_level>0 advance rd_slot and decrement fill_level; else keep rd_slot (repeat) and pulse underflow next cycle.
REQ-012 Consume SHALL evaluate fill_level before a same-cycle commit; simultaneous commit+consume leaves fill_level unchanged.
REQ-013 ram_rd_addr SHALL be {rd_slot,rd_col} combinationally; rd_col SHALL increment each cycle hdmi_request is high, saturating at 2^LINE_W-1.
REQ-014 pixel_data_out SHALL be registered: hdmi_request in cycle N gives ram_rd_data in N+1 and pixel_data_out in N+2; pixel_data_out SHALL be 0 when hdmi_request delayed by 2 is low.
REQ-015 wr_slot SHALL never equal rd_slot.

Reset
REQ-016 rst SHALL set rd_slot=0, wr_slot=1, wr_col=rd_col=0, fill_level=0, line_reset history=1 (no consume on first cycle), all outputs 0.
REQ-017 rst mid-line SHALL abandon partial lines; no ram_wr_en in the reset cycle.

Configuration
REQ-018 With LINE_RING_STATS_EN defined, overflow_count/underflow_count SHALL increment per overflow/underflow pulse, saturate at 16'hFFFF, clear only on rst.
REQ-019 Without LINE_RING_STATS_EN, both counters SHALL be tied to 0 and no counter logic SHALL be present.

Verification
REQ-020 Write 100 samples, h_sync_in -> fill_level 0->1, wr_slot 1->2, RAM addresses 0x800..0x863.
REQ-021 Commit 3 lines with no consume -> third h_sync_in gives overflow pulse, fill_level stays 2, wr_slot stays 3.
REQ-022 After reset, line_reset rising edge with fill_level 0 -> underflow pulse, rd_slot stays 0, underflow_count=1 (macro defined) / 0 (undefined).
REQ-023 fill_level=1, line_reset edge and h_sync commit same cycle -> fill_level stays 1, rd_slot 0->1, wr_slot 2->3.
REQ-024 Line with pixel k=0xA0A0A0+k at column k; consume; hold hdmi_request 5 cycles from N -> pixel_data_out 0xA0A0A0..0xA0A0A4 in N+2..N+6, 0 at N+7.
REQ-025 Assert rst after 50 writes -> next cycle all outputs 0, wr_slot=1, wr_col=0; 3000 samples in one line -> wr_col holds 2047, ram_wr_en low after 2048 writes.
